// File: rtl/mant_shift_seq.sv
// Multi-cycle mantissa shifter: shifts an operand by a run-time amount,
// at most STEP positions per clock, collecting every bit shifted out into
// a sticky/overflow flag. Operand in and result out use valid/ready.
module mant_shift_seq #(
  parameter int WIDTH = 27,
  parameter int SHW   = 5,
  parameter int STEP  = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_amt,
  input  logic             in_dir,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_sticky,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] ONES = '1;

  state_t           state, state_nx;
  logic [WIDTH-1:0] data_r, data_nx;
  logic [SHW-1:0]   rem_r, rem_nx;
  logic             dir_r, dir_nx;
  logic             sticky_r, sticky_nx;

  logic [SHW-1:0]   k;
  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] lost_mask;

  // Per-cycle step: k = min(STEP, rem_r); shift data_r by k and mark the bits that leave.
  always_comb begin
    k         = SHW'(STEP);
    shifted   = '0;
    lost_mask = '0;
    if (32'(rem_r) < STEP) k = rem_r;
    if (dir_r) begin
      shifted   = data_r >> k;
      lost_mask = ~(ONES << k);
    end else begin
      shifted   = data_r << k;
      lost_mask = ~(ONES >> k);
    end
  end

  // Next-state and register-update logic for the accept/shift/hold sequence.
  always_comb begin
    state_nx  = state;
    data_nx   = data_r;
    rem_nx    = rem_r;
    dir_nx    = dir_r;
    sticky_nx = sticky_r;
    case (state)
      IDLE: begin
        if (in_valid) begin
          data_nx   = in_data;
          rem_nx    = in_amt;
          dir_nx    = in_dir;
          sticky_nx = 1'b0;
          state_nx  = (in_amt != '0) ? SHIFT : DONE;
        end
      end
      SHIFT: begin
        data_nx   = shifted;
        sticky_nx = sticky_r | (|(data_r & lost_mask));
        rem_nx    = rem_r - k;
        // k never exceeds rem_r, so equality means this is the last step.
        if (rem_r == k) state_nx = DONE;
      end
      DONE: begin
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // State and datapath registers; reset clears everything, discarding any in-flight operand.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      data_r   <= '0;
      rem_r    <= '0;
      dir_r    <= 1'b0;
      sticky_r <= 1'b0;
    end else begin
      state    <= state_nx;
      data_r   <= data_nx;
      rem_r    <= rem_nx;
      dir_r    <= dir_nx;
      sticky_r <= sticky_nx;
    end
  end

  assign in_ready   = (state == IDLE);
  assign out_valid  = (state == DONE);
  assign busy       = (state != IDLE);
  assign out_data   = data_r;
  assign out_sticky = sticky_r;

endmodule

// File: tb/tb_mant_shift_seq.sv
// Self-checking bench for mant_shift_seq: directed cases plus random
// operands compared against an arithmetic reference model.
module tb_mant_shift_seq;

  localparam int WIDTH = 27;
  localparam int SHW   = 5;
  localparam int STEP  = 2;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [SHW-1:0]   in_amt;
  logic             in_dir;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_sticky;
  logic             busy;

  int tests;
  int fails;

  mant_shift_seq #(.WIDTH(WIDTH), .SHW(SHW), .STEP(STEP)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_amt    (in_amt),
    .in_dir    (in_dir),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sticky(out_sticky),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: wide arithmetic shift; sticky is OR of everything that falls off.
  task automatic model(input logic [WIDTH-1:0] d, input int amt, input logic dir,
                       output logic [WIDTH-1:0] res, output logic stk, output int lat);
    logic [63:0] wide;
    logic [63:0] mask;
    if (!dir) begin
      wide = 64'(d) << amt;
      res  = wide[WIDTH-1:0];
      stk  = |(wide >> WIDTH);
    end else begin
      wide = 64'(d);
      mask = (64'd1 << amt) - 64'd1;
      res  = WIDTH'(wide >> amt);
      stk  = |(wide & mask);
    end
    lat = 1 + (amt + STEP - 1) / STEP;
  endtask

  // One full transaction, checked for latency, result, backpressure stability and release.
  task automatic run_op(input string tag, input logic [WIDTH-1:0] d, input int amt,
                        input logic dir, input int hold);
    logic [WIDTH-1:0] exp_d;
    logic             exp_s;
    int               exp_lat;
    int               cyc;
    model(d, amt, dir, exp_d, exp_s, exp_lat);
    chk({tag, "_ready_before"}, 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    in_data  = d;
    in_amt   = SHW'(amt);
    in_dir   = dir;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    cyc = 1;
    while (!out_valid && cyc < 100) begin
      in_data = WIDTH'($urandom);
      in_amt  = SHW'($urandom);
      in_dir  = 1'($urandom);
      @(negedge clk);
      cyc++;
    end
    chk({tag, "_latency"}, 64'(cyc), 64'(exp_lat));
    chk({tag, "_data"}, 64'(out_data), 64'(exp_d));
    chk({tag, "_sticky"}, 64'(out_sticky), 64'(exp_s));
    chk({tag, "_busy_ready"}, {62'd0, busy, in_ready}, 64'd2);
    for (int i = 0; i < hold; i++) begin
      in_data = WIDTH'($urandom);
      in_valid = 1'($urandom);
      @(negedge clk);
      chk({tag, "_hold"}, {out_valid, in_ready, out_sticky, out_data},
          {1'b1, 1'b0, exp_s, exp_d});
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_release"}, {62'd0, in_ready, out_valid}, 64'd2);
  endtask

  initial begin
    logic [WIDTH-1:0] rd;
    int               ra;
    logic             rdir;
    int               seen;
    tests     = 0;
    fails     = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_amt    = '0;
    in_dir    = 1'b0;
    out_ready = 1'b0;
    #12;
    chk("reset_state", {in_ready, out_valid, busy, out_sticky, 32'(out_data)},
        {1'b1, 1'b0, 1'b0, 1'b0, 32'd0});
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_op("left2", 27'h0000001, 2, 1'b0, 0);
    run_op("right3_sticky", 27'h000000F, 3, 1'b1, 1);
    run_op("underflow", 27'h4000000, 31, 1'b1, 0);
    run_op("underflow_zero", 27'h0000000, 31, 1'b1, 0);
    run_op("left_overflow", 27'h4000001, 1, 1'b0, 0);
    run_op("zero_amt_bp", 27'h5A5A5A5, 0, 1'b0, 5);
    run_op("left_full", 27'h7FFFFFF, 30, 1'b0, 2);

    // Reset during SHIFT: accept amt=31, assert rst_n in cycle 5.
    in_valid = 1'b1;
    in_data  = 27'h7FFFFFF;
    in_amt   = 5'd31;
    in_dir   = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midreset_outputs", {in_ready, out_valid, busy, out_sticky, 32'(out_data)},
        {1'b1, 1'b0, 1'b0, 1'b0, 32'd0});
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    seen = 0;
    repeat (25) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    out_ready = 1'b0;
    chk("midreset_no_valid", 64'(seen), 64'd0);

    for (int n = 0; n < 30; n++) begin
      rd   = WIDTH'($urandom);
      ra   = int'($urandom_range(0, 31));
      rdir = 1'($urandom);
      run_op("rand", rd, ra, rdir, int'($urandom_range(0, 3)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mant_shift_seq.md
# mant_shift_seq

Multi-cycle, parametrised mantissa shifter for the floating-point datapath. It supersedes the fixed 27-bit, 2-position shift cells. It accepts an operand, a run-time shift amount and a direction, then shifts by up to STEP positions per clock. It reports the result with a sticky/lost-bit flag over a valid/ready handshake. The adder alignment and normalisation stages use it where a full combinational barrel shifter costs too much area.

## Interface
- WIDTH, 27: operand/result width in bits (mantissa plus guard/round/sticky).
- SHW, 5: width of the shift-amount field; maximum amount is 2^SHW-1.
- STEP, 2: maximum positions shifted per clock; legal range 1 <= STEP <= WIDTH.

- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- in_valid  in  1  operand present.
- in_ready  out  1  block can accept an operand; equals (state == IDLE).
- in_data  in  WIDTH  operand.
- in_amt  in  SHW  shift amount, unsigned.
- in_dir  in  1  0 = shift left (toward MSB), 1 = logical shift right.
- out_valid  out  1  result present; equals (state == DONE).
- out_ready  in  1  consumer takes the result.
- out_data  out  WIDTH  shifted result, zero-filled.
- out_sticky  out  1  OR of every 1-bit shifted out of the operand: the sticky bit for right shifts, the overflow flag for left shifts.
- busy  out  1  state != IDLE.

## Operation
- Registers:
  - data_r (WIDTH bits)
  - rem_r (SHW bits, positions still to shift)
  - dir_r
  - sticky_r
  - 2-bit state
- State IDLE:
  - in_ready=1.
  - On in_valid: data_r<=in_data, rem_r<=in_amt, dir_r<=in_dir, sticky_r<=0.
  - Next state is SHIFT if in_amt!=0, else DONE.
- State SHIFT, once per cycle:
  - k = min(STEP, rem_r).
  - data_r shifts by k in direction dir_r, zero-filled.
  - sticky_r <= sticky_r | (OR of the k bits leaving the word).
  - rem_r <= rem_r - k.
  - When rem_r - k == 0, next state is DONE.
- State DONE:
  - out_valid=1; out_data=data_r; out_sticky=sticky_r.
  - All stable until out_ready=1, then IDLE.
- Amounts >= WIDTH:
  - No special path; the iteration yields out_data=0.
  - out_sticky = OR of all input bits.
- in_data, in_amt and in_dir are sampled only on the accept edge. Changes afterwards have no effect.
- in_ready is low in SHIFT and DONE. No new operand is accepted in the same cycle as the output handshake.
- Inputs in_valid/out_ready are don't-care in states where they are not consulted.

## Timing
- Reset (rst_n low, asynchronous):
  - state=IDLE; data_r=0, rem_r=0, sticky_r=0, dir_r=0.
  - Outputs: in_ready=1, out_valid=0, out_data=0, out_sticky=0, busy=0.
  - Output values are data_r/sticky_r directly, not gated by out_valid.
- Latency:
  - Let cycle 0 be the accept cycle (in_valid & in_ready).
  - out_valid first asserts in cycle 1 + ceil(in_amt/STEP).
  - in_amt=0 gives latency 1.
  - Worst case with defaults (amt=31, STEP=2) is 17.
- Throughput: one operand per (latency + 1) cycles when out_ready is held high. IDLE always occupies one cycle between operands.
- Backpressure: DONE holds indefinitely, with out_data/out_sticky/out_valid stable every cycle.
- Reset asserted mid-SHIFT or mid-DONE: immediate return to the reset values above. The in-flight operand is discarded; no out_valid pulse.
- rem_r never underflows, because k <= rem_r by construction.

## Test plan
- Reset mid-operation: accept in_amt=31 and drop rst_n in cycle 5 → outputs immediately at reset values (in_ready=1, out_valid=0, out_data=0, out_sticky=0, busy=0). After release, no out_valid ever asserts for the discarded operand.
- Left shift, defaults: in_data=27'h0000001, in_amt=2, in_dir=0 → out_data=27'h0000004, out_sticky=0, out_valid in cycle 2.
- Right shift with sticky: in_data=27'h000000F, in_amt=3, in_dir=1 → out_data=27'h0000001, out_sticky=1, out_valid in cycle 3 (odd amount, final step k=1).
- Full underflow: in_data=27'h4000000, in_amt=31, in_dir=1 → out_data=0, out_sticky=1, out_valid in cycle 17. Repeat with in_data=0 → out_sticky=0.
- Left overflow: in_data=27'h4000001, in_amt=1, in_dir=0 → out_data=27'h0000002, out_sticky=1, out_valid in cycle 2.
- Backpressure and zero amount: in_amt=0, out_ready low for 5 cycles → out_valid=1 from cycle 1, out_data equals in_data and is stable, in_ready=0. Raise out_ready → in_ready=1 in the next cycle. Also toggle in_data while in SHIFT and confirm no effect.
